pc_next_unit: RTL and testbench



---
 rtl/pc_next_unit.sv | 95 +++++++++
 tb/tb_pc_next_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_next_unit.sv
// Next-PC / fetch-control stage feeding the PC register; sequences imem fetches,
// branch redirects, stalls and HALT. Optional fetch counter under PC_FETCH_COUNT_EN.
module pc_next_unit #(
  parameter int          WIDTH    = 16,
  parameter int          INC      = 2,
  parameter logic [3:0]  HALT_OPC = 4'hF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pc_q,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             imem_valid,
  input  logic [WIDTH-1:0] imem_instr,
  output logic             fetch_req,
  output logic [WIDTH-1:0] pc_d,
  output logic             pc_wen,
  output logic             if_valid,
  output logic [WIDTH-1:0] instr_out,
  output logic             halted
`ifdef PC_FETCH_COUNT_EN
  ,
  output logic [15:0]      fetch_count
`endif
);

  typedef enum logic [1:0] {FETCH, DRAIN, HALTED} state_t;

  state_t state, nxt;
  logic   is_halt;

  assign is_halt = (imem_instr[WIDTH-1 -: 4] == HALT_OPC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= nxt;
  end

  always_comb begin
    nxt       = state;
    fetch_req = 1'b0;
    pc_d      = '0;
    pc_wen    = 1'b0;
    if_valid  = 1'b0;
    halted    = 1'b0;
    if (rst) begin
      nxt = FETCH;
    end else if (br_taken) begin
      // Redirect wins over everything; a fetch in flight must be drained.
      pc_d   = br_target;
      pc_wen = 1'b1;
      halted = (state == HALTED);
      case (state)
        FETCH:   nxt = imem_valid ? FETCH : DRAIN;
        DRAIN:   nxt = DRAIN;
        HALTED:  nxt = FETCH;
        default: nxt = FETCH;
      endcase
    end else begin
      case (state)
        FETCH: begin
          fetch_req = 1'b1;
          if (imem_valid && !stall) begin
            if_valid = 1'b1;
            if (is_halt) begin
              // PC stays on the HALT word so a later redirect is the only way out.
              nxt = HALTED;
            end else begin
              pc_d   = pc_q + WIDTH'(INC);
              pc_wen = 1'b1;
            end
          end
        end
        DRAIN: begin
          if (imem_valid) nxt = FETCH;
        end
        HALTED: begin
          halted = 1'b1;
        end
        default: nxt = FETCH;
      endcase
    end
  end

  assign instr_out = if_valid ? imem_instr : '0;

`ifdef PC_FETCH_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              fetch_count <= '0;
    else if (if_valid && fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit with a behavioural PC register closing the loop.
module tb_pc_next_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc_q;
  logic        stall, br_taken, imem_valid;
  logic [15:0] br_target, imem_instr;
  logic        fetch_req, pc_wen, if_valid, halted;
  logic [15:0] pc_d, instr_out;
`ifdef PC_FETCH_COUNT_EN
  logic [15:0] fetch_count;
`endif

  // PC register model with a bench-side preload
  logic        ld;
  logic [15:0] ld_val;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         pc_q <= '0;
    else if (ld)     pc_q <= ld_val;
    else if (pc_wen) pc_q <= pc_d;
  end

  pc_next_unit dut (
    .clk        (clk),
    .rst        (rst),
    .pc_q       (pc_q),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .imem_valid (imem_valid),
    .imem_instr (imem_instr),
    .fetch_req  (fetch_req),
    .pc_d       (pc_d),
    .pc_wen     (pc_wen),
    .if_valid   (if_valid),
    .instr_out  (instr_out),
    .halted     (halted)
`ifdef PC_FETCH_COUNT_EN
    ,
    .fetch_count(fetch_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [15:0] v);
    imem_valid = 1'b0; br_taken = 1'b0; stall = 1'b0;
    ld = 1'b1; ld_val = v;
    tick();
    ld = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ld = 1'b0; ld_val = '0;
    stall = 1'b0; br_taken = 1'b1; br_target = 16'h0055;
    imem_valid = 1'b1; imem_instr = 16'h1234;
    #3;
    chk("rst_fetch_req", fetch_req, 0);
    chk("rst_pc_wen",    pc_wen,    0);
    chk("rst_if_valid",  if_valid,  0);
    chk("rst_halted",    halted,    0);
    chk("rst_pc_d",      pc_d,      0);
    chk("rst_instr_out", instr_out, 0);
    tick();
    rst = 1'b0; br_taken = 1'b0;

    // sequential fetch
    for (int i = 0; i < 4; i++) begin
      #3;
      chk("seq_pc_q",   pc_q,      32'(2*i));
      chk("seq_pc_d",   pc_d,      32'(2*i+2));
      chk("seq_wen",    pc_wen,    1);
      chk("seq_ifv",    if_valid,  1);
      chk("seq_instr",  instr_out, 32'h1234);
      tick();
    end

    // stall holds PC and keeps requesting
    preload(16'h0010);
    imem_valid = 1'b1; stall = 1'b1; imem_instr = 16'h2345;
    for (int i = 0; i < 3; i++) begin
      #3;
      chk("stall_wen",   pc_wen,    0);
      chk("stall_ifv",   if_valid,  0);
      chk("stall_req",   fetch_req, 1);
      chk("stall_instr", instr_out, 0);
      tick();
    end
    stall = 1'b0;
    #3;
    chk("unstall_pc_d", pc_d,     32'h0012);
    chk("unstall_wen",  pc_wen,   1);
    chk("unstall_ifv",  if_valid, 1);
    tick();
    chk("unstall_pc_q", pc_q,     32'h0012);

    // redirect with fetch outstanding -> DRAIN drops the late word
    imem_valid = 1'b0; br_taken = 1'b1; br_target = 16'h0100;
    #3;
    chk("redir_pc_d", pc_d,     32'h0100);
    chk("redir_wen",  pc_wen,   1);
    chk("redir_ifv",  if_valid, 0);
    tick();
    br_taken = 1'b0; imem_valid = 1'b1; imem_instr = 16'h2222; stall = 1'b1;
    #3;
    chk("drain_pc_q", pc_q,      32'h0100);
    chk("drain_ifv",  if_valid,  0);
    chk("drain_req",  fetch_req, 0);
    chk("drain_wen",  pc_wen,    0);
    tick();
    imem_valid = 1'b0; stall = 1'b0;
    #3;
    chk("refetch_req", fetch_req, 1);
    tick();

    // HALT
    preload(16'h0040);
    imem_valid = 1'b1; imem_instr = 16'hF000;
    #3;
    chk("halt_ifv",   if_valid,  1);
    chk("halt_wen",   pc_wen,    0);
    chk("halt_instr", instr_out, 32'hF000);
    tick();
    imem_instr = 16'h1111; stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #3;
      chk("halted",      halted,    1);
      chk("halted_req",  fetch_req, 0);
      chk("halted_ifv",  if_valid,  0);
      chk("halted_pc_q", pc_q,      32'h0040);
      tick();
    end
    stall = 1'b0; imem_valid = 1'b0; br_taken = 1'b1; br_target = 16'h0008;
    #3;
    chk("unhalt_pc_d", pc_d,   32'h0008);
    chk("unhalt_wen",  pc_wen, 1);
    tick();
    br_taken = 1'b0;
    #3;
    chk("unhalt_halted", halted,    0);
    chk("unhalt_req",    fetch_req, 1);
    chk("unhalt_pc_q",   pc_q,      32'h0008);
    tick();

    // wrap
    preload(16'hFFFE);
    imem_valid = 1'b1; imem_instr = 16'h1234;
    #3;
    chk("wrap_pc_d", pc_d,   32'h0000);
    chk("wrap_wen",  pc_wen, 1);
    tick();

    // branch with data arriving: data discarded, stays in FETCH
    br_taken = 1'b1; br_target = 16'h0300;
    #3;
    chk("brv_ifv",  if_valid, 0);
    chk("brv_pc_d", pc_d,     32'h0300);
    tick();
    br_taken = 1'b0; imem_valid = 1'b0;
    #3;
    chk("brv_req", fetch_req, 1);
    tick();

    // async reset while in DRAIN
    br_taken = 1'b1; br_target = 16'h0200;
    tick();
    br_taken = 1'b0;
    #2;
    chk("pre_rst_drain_req", fetch_req, 0);
`ifdef PC_FETCH_COUNT_EN
    chk("count_before_rst", fetch_count, 7);
`endif
    rst = 1'b1;
    #1;
    chk("arst_req",    fetch_req, 0);
    chk("arst_wen",    pc_wen,    0);
    chk("arst_ifv",    if_valid,  0);
    chk("arst_halted", halted,    0);
`ifdef PC_FETCH_COUNT_EN
    chk("arst_count",  fetch_count, 0);
`endif
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_req",  fetch_req, 1);
    chk("post_rst_pc_q", pc_q,      0);
    tick();
    imem_valid = 1'b1; imem_instr = 16'h4321;
    #3;
    chk("post_rst_ifv",  if_valid, 1);
    chk("post_rst_pc_d", pc_d,     32'h0002);
    tick();
    imem_valid = 1'b0;
`ifdef PC_FETCH_COUNT_EN
    #3;
    chk("post_rst_count", fetch_count, 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
